// File: rtl/mbist_resp_cmp.sv
`timescale 1ns/1ps
// mbist_resp_cmp: response checker for the MBIST checkerboard engine.
// Delays each read by the memory latency, compares it with the expected pattern and records the first failure.
module mbist_resp_cmp #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4,
    parameter int RD_LAT = 1,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_in,
    input  logic              w_en_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] exp_in,
    input  logic              last_in,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy_out,
    output logic              done_out,
    output logic              fail_out,
    output logic [ERR_W-1:0]  err_cnt_out,
    output logic [ADDR_W-1:0] fail_addr_out,
    output logic [DATA_W-1:0] fail_exp_out,
    output logic [DATA_W-1:0] fail_act_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0]       DRAIN_LAST = 3'(RD_LAT - 1);
    localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE    = ERR_W'(1);

    state_t            state_q, state_d;
    logic [2:0]        drain_cnt_q, drain_cnt_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [ADDR_W-1:0] addr_q [RD_LAT];
    logic [ADDR_W-1:0] addr_d [RD_LAT];
    logic [DATA_W-1:0] exp_q  [RD_LAT];
    logic [DATA_W-1:0] exp_d  [RD_LAT];

    logic              fail_q, fail_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_exp_q, fail_exp_d;
    logic [DATA_W-1:0] fail_act_q, fail_act_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              rd_stb_s;
    logic              cmp_vld_s;
    logic              mism_s;

    assign rd_stb_s  = (state_q == S_RUN) & en_in & ~w_en_in;
    assign cmp_vld_s = vld_q[RD_LAT-1];
    // Gating with the valid bit keeps undriven read data out of the result.
    assign mism_s    = cmp_vld_s & (exp_q[RD_LAT-1] != mem_dout);

    // Read pipeline: stage 0 captures the strobe, later stages shift toward the compare point.
    always_comb begin
        vld_d     = '0;
        addr_d    = '{default: '0};
        exp_d     = '{default: '0};
        vld_d[0]  = rd_stb_s;
        addr_d[0] = addr_in;
        exp_d[0]  = exp_in;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            addr_d[i] = addr_q[i-1];
            exp_d[i]  = exp_q[i-1];
        end
    end

    // Pass FSM plus result update; entering a pass clears results after any compare update.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        fail_d      = fail_q;
        err_cnt_d   = err_cnt_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_act_d  = fail_act_q;

        if (mism_s) begin
            fail_d = 1'b1;
            if (err_cnt_q != ERR_MAX) begin
                err_cnt_d = err_cnt_q + ERR_ONE;
            end else begin
                err_cnt_d = err_cnt_q;
            end
            if (!fail_q) begin
                fail_addr_d = addr_q[RD_LAT-1];
                fail_exp_d  = exp_q[RD_LAT-1];
                fail_act_d  = mem_dout;
            end else begin
                fail_addr_d = fail_addr_q;
                fail_exp_d  = fail_exp_q;
                fail_act_d  = fail_act_q;
            end
        end else begin
            fail_d = fail_q;
        end

        case (state_q)
            S_IDLE: begin
                if (en_in) begin
                    state_d     = S_RUN;
                    fail_d      = 1'b0;
                    err_cnt_d   = '0;
                    fail_addr_d = '0;
                    fail_exp_d  = '0;
                    fail_act_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_in || !en_in) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = 3'd0;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d     = S_DONE;
                    drain_cnt_d = 3'd0;
                end else begin
                    drain_cnt_d = drain_cnt_q + 3'd1;
                end
            end
            S_DONE: begin
                if (!en_in) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                drain_cnt_d = 3'd0;
            end
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // State, pipeline and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            drain_cnt_q <= 3'd0;
            vld_q       <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                addr_q[i] <= '0;
                exp_q[i]  <= '0;
            end
            fail_q      <= 1'b0;
            err_cnt_q   <= '0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            vld_q       <= vld_d;
            for (int i = 0; i < RD_LAT; i++) begin
                addr_q[i] <= addr_d[i];
                exp_q[i]  <= exp_d[i];
            end
            fail_q      <= fail_d;
            err_cnt_q   <= err_cnt_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_act_q  <= fail_act_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy_out      = busy_q;
    assign done_out      = done_q;
    assign fail_out      = fail_q;
    assign err_cnt_out   = err_cnt_q;
    assign fail_addr_out = fail_addr_q;
    assign fail_exp_out  = fail_exp_q;
    assign fail_act_out  = fail_act_q;

endmodule
